// File: rtl/adc_par_pkg.sv
// Shared types and defaults for the parallel-ADC sequencer: FSM states, timing
// defaults and AD7606 oversampling codes.
package adc_par_pkg;

  typedef enum logic [2:0] {
    RSTP, IDLE, CONV, WDLY, WBSY, READ, DONE
  } state_t;

  localparam int DEF_DW       = 16;
  localparam int DEF_N_CH     = 8;
  localparam int DEF_CHW      = 3;
  localparam int DEF_PER_W    = 16;
  localparam int DEF_RST_CYC  = 255;
  localparam int DEF_CONV_CYC = 2;
  localparam int DEF_BUSY_DLY = 5;
  localparam int DEF_RD_LO    = 3;
  localparam int DEF_RD_HI    = 1;
  localparam int DEF_BUSY_TMO = 4095;

  localparam logic [2:0] OS_NONE = 3'd0;
  localparam logic [2:0] OS_2    = 3'd1;
  localparam logic [2:0] OS_4    = 3'd2;
  localparam logic [2:0] OS_8    = 3'd3;
  localparam logic [2:0] OS_16   = 3'd4;
  localparam logic [2:0] OS_32   = 3'd5;
  localparam logic [2:0] OS_64   = 3'd6;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_par_seq_if.sv
// Sample stream carrying one ADC word per beat with its channel tag and frame-last flag.
interface adc_par_seq_if #(
  parameter int DW  = 16,
  parameter int CHW = 3
);
  logic           valid;
  logic           ready;
  logic [DW-1:0]  data;
  logic [CHW-1:0] ch;
  logic           last;

  modport master (output valid, data, ch, last, input ready);
  modport slave  (input valid, data, ch, last, output ready);
endinterface

// File: rtl/adc_period_timer.sv
// Frame period counter: emits a registered tick every 'period' cycles while run is
// high (first tick one cycle after run rises) and flags the rising edge of run.
module adc_period_timer #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [PER_W-1:0] period,
  output logic             tick,
  output logic             run_rise
);

  logic [PER_W-1:0] cnt;
  logic             run_q;

  assign run_rise = run & ~run_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      tick  <= 1'b0;
      run_q <= 1'b0;
    end else begin
      run_q <= run;
      if (!run) begin
        cnt  <= '0;
        tick <= 1'b0;
      end else begin
        tick <= (cnt == '0);
        // period 0 or 1 keeps the counter parked so a tick is issued every cycle
        if (period <= PER_W'(1) || cnt >= period - PER_W'(1))
          cnt <= '0;
        else
          cnt <= cnt + PER_W'(1);
      end
    end
  end

endmodule

// File: rtl/adc_par_seq.sv
// AD7606-class parallel ADC sequencer: convst/busy/cs/rd pin timing, per-frame channel
// mask and sample stream. Optional busy watchdog enabled by defining ADC_BUSY_TMO_EN.
module adc_par_seq
  import adc_par_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int N_CH     = DEF_N_CH,
  parameter int CHW      = DEF_CHW,
  parameter int PER_W    = DEF_PER_W,
  parameter int RST_CYC  = DEF_RST_CYC,
  parameter int CONV_CYC = DEF_CONV_CYC,
  parameter int BUSY_DLY = DEF_BUSY_DLY,
  parameter int RD_LO    = DEF_RD_LO,
  parameter int RD_HI    = DEF_RD_HI,
  parameter int BUSY_TMO = DEF_BUSY_TMO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    ad_data,
  input  logic             ad_busy,
  output logic [2:0]       ad_os,
  output logic             ad_cs,
  output logic             ad_rd,
  output logic             ad_reset,
  output logic             ad_convst,
  input  logic             cfg_run,
  input  logic [N_CH-1:0]  cfg_mask,
  input  logic [2:0]       cfg_os,
  input  logic [PER_W-1:0] cfg_period,
  adc_par_seq_if.master    smp,
  output logic             st_overrun,
  output logic             st_miss,
  output logic             st_tmo
);

  localparam int CYC_W = $clog2(max2(max2(RST_CYC, BUSY_TMO),
                                     max2(max2(CONV_CYC, BUSY_DLY), max2(RD_LO, RD_HI))) + 1);

  state_t          state, state_nx;
  logic [CYC_W-1:0] cyc, cyc_nx;
  logic [CHW-1:0]  idx, idx_nx;
  logic            rd_hi, rd_hi_nx;
  logic [N_CH-1:0] mask_lat;
  logic            start, cap;
  logic            tick, run_rise;
`ifdef ADC_BUSY_TMO_EN
  logic            tmo_hit;
`endif

  logic            vld_p0;
  logic [DW-1:0]   data_p0;
  logic [CHW-1:0]  ch_p0;
  logic            last_p0;

  function automatic logic [CHW-1:0] msb_idx(input logic [N_CH-1:0] m);
    msb_idx = '0;
    for (int i = 0; i < N_CH; i++)
      if (m[i]) msb_idx = CHW'(i);
  endfunction

  adc_period_timer #(.PER_W(PER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (cfg_run),
    .period   (cfg_period),
    .tick     (tick),
    .run_rise (run_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RSTP;
      cyc      <= '0;
      idx      <= '0;
      rd_hi    <= 1'b0;
      mask_lat <= '0;
      ad_os    <= 3'd0;
    end else begin
      state <= state_nx;
      cyc   <= cyc_nx;
      idx   <= idx_nx;
      rd_hi <= rd_hi_nx;
      if (state == IDLE) ad_os <= cfg_os;
      if (start) mask_lat <= cfg_mask;
    end
  end

  always_comb begin
    state_nx = state;
    cyc_nx   = cyc + CYC_W'(1);
    idx_nx   = idx;
    rd_hi_nx = rd_hi;
    start    = 1'b0;
    cap      = 1'b0;
`ifdef ADC_BUSY_TMO_EN
    tmo_hit  = 1'b0;
`endif
    case (state)
      RSTP: if (cyc == CYC_W'(RST_CYC - 1)) begin
        state_nx = IDLE;
        cyc_nx   = '0;
      end
      IDLE: begin
        cyc_nx = '0;
        if (tick && cfg_run && (|cfg_mask)) begin
          start    = 1'b1;
          state_nx = CONV;
        end
      end
      CONV: if (cyc == CYC_W'(CONV_CYC - 1)) begin
        state_nx = WDLY;
        cyc_nx   = '0;
      end
      WDLY: if (cyc == CYC_W'(BUSY_DLY - 1)) begin
        state_nx = WBSY;
        cyc_nx   = '0;
      end
      WBSY: begin
        if (!ad_busy) begin
          state_nx = READ;
          cyc_nx   = '0;
          idx_nx   = '0;
          rd_hi_nx = 1'b0;
        end
`ifdef ADC_BUSY_TMO_EN
        else if (cyc == CYC_W'(BUSY_TMO - 1)) begin
          tmo_hit  = 1'b1;
          state_nx = RSTP;
          cyc_nx   = '0;
        end
`else
        else cyc_nx = '0;
`endif
      end
      READ: begin
        if (!rd_hi) begin
          if (cyc == CYC_W'(RD_LO - 1)) begin
            cap      = 1'b1;
            rd_hi_nx = 1'b1;
            cyc_nx   = '0;
          end
        end else if (cyc == CYC_W'(RD_HI - 1)) begin
          cyc_nx   = '0;
          rd_hi_nx = 1'b0;
          if (idx == CHW'(N_CH - 1)) state_nx = DONE;
          else idx_nx = idx + CHW'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        cyc_nx   = '0;
      end
      default: begin
        state_nx = RSTP;
        cyc_nx   = '0;
      end
    endcase
  end

  assign ad_reset  = (state == RSTP);
  assign ad_convst = (state != CONV);
  assign ad_cs     = (state != READ);
  assign ad_rd     = !((state == READ) && !rd_hi);

  // Stage p0: word taken on the last rd-low cycle; masked-off channels never become valid.
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= cap && mask_lat[idx];
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      data_p0 <= ad_data;
      ch_p0   <= idx;
      last_p0 <= (idx == msb_idx(mask_lat));
    end
  end

  // Output register: single entry, loads from p0 unless still holding an unaccepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp.valid <= 1'b0;
      smp.data  <= '0;
      smp.ch    <= '0;
      smp.last  <= 1'b0;
    end else if (vld_p0 && (!smp.valid || smp.ready)) begin
      smp.valid <= 1'b1;
      smp.data  <= data_p0;
      smp.ch    <= ch_p0;
      smp.last  <= last_p0;
    end else if (smp.ready) begin
      smp.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_overrun <= 1'b0;
      st_miss    <= 1'b0;
    end else begin
      if (run_rise) begin
        st_overrun <= 1'b0;
        st_miss    <= 1'b0;
      end
      if (vld_p0 && smp.valid && !smp.ready) st_overrun <= 1'b1;
      if (tick && (state != IDLE) && (cfg_period != '0)) st_miss <= 1'b1;
    end
  end

`ifdef ADC_BUSY_TMO_EN
  always_ff @(posedge clk) begin
    if (rst)           st_tmo <= 1'b0;
    else if (tmo_hit)  st_tmo <= 1'b1;
    else if (run_rise) st_tmo <= 1'b0;
  end
`else
  assign st_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_adc_par_seq.sv
// Directed bench for adc_par_seq with a small AD7606-like pin model; the busy-timeout
// scenario runs only when ADC_BUSY_TMO_EN is defined.
module tb_adc_par_seq;
  import adc_par_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ad_data;
  logic        ad_busy;
  logic [2:0]  ad_os;
  logic        ad_cs, ad_rd, ad_reset, ad_convst;
  logic        cfg_run;
  logic [7:0]  cfg_mask;
  logic [2:0]  cfg_os;
  logic [15:0] cfg_period;
  logic        st_overrun, st_miss, st_tmo;

  adc_par_seq_if #(.DW(16), .CHW(3)) smp_if ();

  adc_par_seq #(.BUSY_TMO(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .ad_data    (ad_data),
    .ad_busy    (ad_busy),
    .ad_os      (ad_os),
    .ad_cs      (ad_cs),
    .ad_rd      (ad_rd),
    .ad_reset   (ad_reset),
    .ad_convst  (ad_convst),
    .cfg_run    (cfg_run),
    .cfg_mask   (cfg_mask),
    .cfg_os     (cfg_os),
    .cfg_period (cfg_period),
    .smp        (smp_if.master),
    .st_overrun (st_overrun),
    .st_miss    (st_miss),
    .st_tmo     (st_tmo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model and pin monitor, evaluated away from the active edge
  logic [15:0] rd_cnt = 16'd0;
  int          busy_cnt = 0;
  logic        busy_stuck = 1'b0;
  logic        rd_q = 1'b1, convst_q = 1'b1, reset_q = 1'b1;
  int          rd_falls = 0;
  int          conv_rise_t = -1;
  int          reset_rise_t = -1;
  int          conv_t[$];
  logic [15:0] s_data[$];
  logic [2:0]  s_ch[$];
  logic        s_last[$];

  assign ad_data = 16'h1000 + rd_cnt;
  assign ad_busy = busy_stuck | (busy_cnt != 0);

  always @(negedge clk) begin
    if (smp_if.valid && smp_if.ready) begin
      s_data.push_back(smp_if.data);
      s_ch.push_back(smp_if.ch);
      s_last.push_back(smp_if.last);
    end
    if (!ad_rd && rd_q) rd_falls = rd_falls + 1;
    if (ad_rd && !rd_q) rd_cnt = rd_cnt + 16'd1;
    if (!ad_convst && convst_q) conv_t.push_back(cyc);
    if (ad_convst && !convst_q) conv_rise_t = cyc;
    if (ad_reset && !reset_q) reset_rise_t = cyc;
    if (!ad_convst) begin
      rd_cnt   = 16'd0;
      busy_cnt = 10;
    end else if (busy_cnt != 0) begin
      busy_cnt = busy_cnt - 1;
    end
    rd_q     = ad_rd;
    convst_q = ad_convst;
    reset_q  = ad_reset;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    s_data.delete();
    s_ch.delete();
    s_last.delete();
    conv_t.delete();
    rd_falls = 0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n = 0;
    while (ad_reset && n < 1000) begin
      n++;
      step(1);
    end
    total++; if (n !== 255) begin bad++; $display("FAIL reset_len: got %0d want 255", n); end
    total++; if (ad_reset !== 1'b0) begin bad++; $display("FAIL reset_end: got %b want 0", ad_reset); end
    total++; if (ad_cs !== 1'b1) begin bad++; $display("FAIL idle_cs: got %b want 1", ad_cs); end
    total++; if (ad_rd !== 1'b1) begin bad++; $display("FAIL idle_rd: got %b want 1", ad_rd); end
    total++; if (ad_convst !== 1'b1) begin bad++; $display("FAIL idle_convst: got %b want 1", ad_convst); end
    total++; if (ad_os !== 3'd0) begin bad++; $display("FAIL idle_os: got %0d want 0", ad_os); end
    total++; if (smp_if.valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", smp_if.valid); end
    total++; if (smp_if.data !== 16'h0) begin bad++; $display("FAIL idle_data: got %h want 0000", smp_if.data); end
    total++; if ({st_overrun, st_miss, st_tmo} !== 3'b000) begin
      bad++; $display("FAIL idle_flags: got %b want 000", {st_overrun, st_miss, st_tmo});
    end
  endtask

  task automatic test_full_frame();
    int n;
    clear_logs();
    cfg_mask = 8'hFF; cfg_period = 16'd200; cfg_os = OS_4; smp_if.ready = 1'b1;
    cfg_run = 1'b1;
    n = 0;
    while (s_data.size() < 16 && n < 600) begin n++; step(1); end
    total++; if (s_data.size() < 16) begin bad++; $display("FAIL full_count: got %0d want 16", s_data.size()); end
    for (int i = 0; i < 16 && i < s_data.size(); i++) begin
      total++; if (s_data[i] !== 16'h1000 + 16'(i % 8)) begin
        bad++; $display("FAIL full_data[%0d]: got %h want %h", i, s_data[i], 16'h1000 + 16'(i % 8));
      end
      total++; if (s_ch[i] !== 3'(i % 8)) begin bad++; $display("FAIL full_ch[%0d]: got %0d want %0d", i, s_ch[i], i % 8); end
      total++; if (s_last[i] !== ((i % 8) == 7)) begin bad++; $display("FAIL full_last[%0d]: got %b want %b", i, s_last[i], (i % 8) == 7); end
    end
    total++; if (conv_t.size() < 2 || (conv_t[1] - conv_t[0]) !== 200) begin
      bad++; $display("FAIL full_period: got %0d frames, spacing wrong (want 200)", conv_t.size());
    end
    total++; if (ad_os !== OS_4) begin bad++; $display("FAIL full_os: got %0d want %0d", ad_os, OS_4); end
    total++; if (st_miss !== 1'b0) begin bad++; $display("FAIL full_miss: got %b want 0", st_miss); end
    cfg_run = 1'b0;
    step(100);
  endtask

  task automatic test_mask();
    int n;
    clear_logs();
    cfg_mask = 8'b0010_0100; cfg_period = 16'd200; smp_if.ready = 1'b1;
    cfg_run = 1'b1;
    n = 0;
    while (s_data.size() < 2 && n < 300) begin n++; step(1); end
    step(60);
    total++; if (s_data.size() !== 2) begin bad++; $display("FAIL mask_count: got %0d want 2", s_data.size()); end
    total++; if (s_data[0] !== 16'h1002 || s_ch[0] !== 3'd2 || s_last[0] !== 1'b0) begin
      bad++; $display("FAIL mask_s0: got %h/%0d/%b want 1002/2/0", s_data[0], s_ch[0], s_last[0]);
    end
    total++; if (s_data[1] !== 16'h1005 || s_ch[1] !== 3'd5 || s_last[1] !== 1'b1) begin
      bad++; $display("FAIL mask_s1: got %h/%0d/%b want 1005/5/1", s_data[1], s_ch[1], s_last[1]);
    end
    total++; if (rd_falls !== 8) begin bad++; $display("FAIL mask_rd_strobes: got %0d want 8", rd_falls); end
    cfg_run = 1'b0;
    step(100);
  endtask

  task automatic test_backpressure();
    clear_logs();
    cfg_mask = 8'hFF; cfg_period = 16'd200; smp_if.ready = 1'b0;
    cfg_run = 1'b1;
    step(100);
    total++; if (smp_if.valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", smp_if.valid); end
    total++; if (smp_if.data !== 16'h1000 || smp_if.ch !== 3'd0) begin
      bad++; $display("FAIL bp_held: got %h/%0d want 1000/0", smp_if.data, smp_if.ch);
    end
    total++; if (st_overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun: got %b want 1", st_overrun); end
    smp_if.ready = 1'b1;
    step(2);
    total++; if (s_data.size() !== 1 || s_data[0] !== 16'h1000) begin
      bad++; $display("FAIL bp_drain: got %0d samples want 1 of 1000", s_data.size());
    end
    total++; if (smp_if.valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", smp_if.valid); end
    cfg_run = 1'b0;
    step(1);
    total++; if (st_overrun !== 1'b1) begin bad++; $display("FAIL bp_sticky: got %b want 1", st_overrun); end
    cfg_run = 1'b1;
    step(1);
    total++; if (st_overrun !== 1'b0) begin bad++; $display("FAIL bp_clear: got %b want 0", st_overrun); end
    cfg_run = 1'b0;
    step(100);
  endtask

  task automatic test_short_period();
    clear_logs();
    cfg_mask = 8'hFF; cfg_period = 16'd20; smp_if.ready = 1'b1;
    cfg_run = 1'b1;
    step(200);
    total++; if (st_miss !== 1'b1) begin bad++; $display("FAIL short_miss: got %b want 1", st_miss); end
    total++; if (st_overrun !== 1'b0) begin bad++; $display("FAIL short_overrun: got %b want 0", st_overrun); end
    total++; if (conv_t.size() < 2) begin bad++; $display("FAIL short_frames: got %0d want >=2", conv_t.size()); end
    for (int i = 1; i < conv_t.size(); i++) begin
      total++; if (((conv_t[i] - conv_t[i-1]) % 20) !== 0 || (conv_t[i] - conv_t[i-1]) < 40) begin
        bad++; $display("FAIL short_spacing[%0d]: got %0d want multiple of 20 >= 40", i, conv_t[i] - conv_t[i-1]);
      end
    end
    total++; if (s_data.size() < 1 || s_data[0] !== 16'h1000) begin
      bad++; $display("FAIL short_first: got %0d samples want first 1000", s_data.size());
    end
    cfg_run = 1'b0;
    step(100);
  endtask

`ifdef ADC_BUSY_TMO_EN
  task automatic test_busy_timeout();
    int n;
    clear_logs();
    reset_rise_t = -1;
    busy_stuck = 1'b1;
    cfg_mask = 8'hFF; cfg_period = 16'd1000; smp_if.ready = 1'b1;
    cfg_run = 1'b1;
    n = 0;
    while (reset_rise_t < 0 && n < 400) begin n++; step(1); end
    total++; if (reset_rise_t < 0 || (reset_rise_t - conv_rise_t) !== 105) begin
      bad++; $display("FAIL tmo_delay: got %0d want 105", reset_rise_t - conv_rise_t);
    end
    total++; if (st_tmo !== 1'b1) begin bad++; $display("FAIL tmo_flag: got %b want 1", st_tmo); end
    step(20);
    total++; if (s_data.size() !== 0) begin bad++; $display("FAIL tmo_samples: got %0d want 0", s_data.size()); end
    busy_stuck = 1'b0;
    cfg_run = 1'b0;
    n = 0;
    while (ad_reset && n < 400) begin n++; step(1); end
    total++; if (ad_reset !== 1'b0) begin bad++; $display("FAIL tmo_recover: got %b want 0", ad_reset); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    cfg_run = 1'b0; cfg_mask = 8'h00; cfg_os = OS_NONE; cfg_period = 16'd0;
    smp_if.ready = 1'b0;
    step(2);
    test_reset();
    test_full_frame();
    test_mask();
    test_backpressure();
    test_short_period();
`ifdef ADC_BUSY_TMO_EN
    test_busy_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
